// File: rtl/request_unit_pkg.sv
// Shared types for the request unit: FSM state encoding and data-request decode.
package request_unit_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    // Returns {write, read}; a write wins when both are requested.
    function automatic logic [1:0] decode_op(input logic dren, input logic dwen);
        return {dwen, dren & ~dwen};
    endfunction

endpackage

// File: rtl/request_unit_if.sv
// Control-unit / memory handshake bundle seen by the request unit.
interface request_unit_if
    import request_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cu_iREN;
    logic             cu_dREN;
    logic             cu_dWEN;
    logic             cu_halt;
    logic             ihit;
    logic             dhit;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pc_en;
    logic             wb_en;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport ru (
        input  cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pc_en, wb_en, halt, instr_cnt, stall_cnt
    );

    modport tb (
        output cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, pc_en, wb_en, halt, instr_cnt, stall_cnt
    );
endinterface

// File: rtl/request_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module request_unit_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;
endmodule

// File: rtl/request_unit.sv
// Sequences instruction fetch and data access, gates PC advance/write-back, latches halt.
module request_unit
    import request_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       nRST,
    request_unit_if.ru ruif
);
    reqstate_t        r_state;
    logic             r_dren;
    logic             r_dwen;
    logic             r_halt;
    logic             w_advance;
    logic             w_wait;
    logic             w_imem_ren;
    logic [1:0]       w_op;
    logic [CNT_W-1:0] w_icnt;
    logic [CNT_W-1:0] w_scnt;

    assign w_op = decode_op(ruif.cu_dREN, ruif.cu_dWEN);

    // PC advance and stall detection; the hit that is not awaited in a state is ignored.
    always_comb begin
        w_advance  = 1'b0;
        w_wait     = 1'b0;
        w_imem_ren = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_ren = ruif.cu_iREN;
                if (ruif.ihit) begin
                    w_advance = !ruif.cu_halt && (w_op == 2'b00);
                end else begin
                    w_wait = 1'b1;
                end
            end
            DATA: begin
                if (ruif.dhit) begin
                    w_advance = 1'b1;
                end else begin
                    w_wait = 1'b1;
                end
            end
            HALTED: begin
                w_advance = 1'b0;
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    // Request sequencing FSM; the data request is latched on entry and held until dhit.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_dren  <= 1'b0;
            r_dwen  <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ruif.ihit && ruif.cu_halt) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                    end else if (ruif.ihit && (w_op != 2'b00)) begin
                        r_state          <= DATA;
                        {r_dwen, r_dren} <= w_op;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                DATA: begin
                    if (ruif.dhit) begin
                        r_state <= FETCH;
                        r_dren  <= 1'b0;
                        r_dwen  <= 1'b0;
                    end else begin
                        r_state <= DATA;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= FETCH;
                    r_dren  <= 1'b0;
                    r_dwen  <= 1'b0;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    request_unit_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (w_advance),
        .count (w_icnt)
    );

    request_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (w_wait),
        .count (w_scnt)
    );

    assign ruif.imemREN   = w_imem_ren;
    assign ruif.dmemREN   = r_dren && (r_state == DATA);
    assign ruif.dmemWEN   = r_dwen && (r_state == DATA);
    assign ruif.pc_en     = w_advance;
    assign ruif.wb_en     = w_advance;
    assign ruif.halt      = r_halt;
    assign ruif.instr_cnt = w_icnt;
    assign ruif.stall_cnt = w_scnt;
endmodule

// File: tb/tb_request_unit.sv
// Directed and randomized checks of request_unit against a behavioural model.
module tb_request_unit;
    localparam longint MAX32 = 64'd4294967295;

    logic CLK = 1'b0;
    logic nRST;
    logic nRST4;
    always #5 CLK = ~CLK;

    request_unit_if #(.CNT_W(32)) ifc ();
    request_unit_if #(.CNT_W(4))  ifc4 ();

    request_unit #(.CNT_W(32)) dut  (.CLK(CLK), .nRST(nRST),  .ruif(ifc));
    request_unit #(.CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST4), .ruif(ifc4));

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is a data op pending (0 none, 1 read, 2 write), has halt been decoded, event totals.
    bit     m_halted = 1'b0;
    int     m_op     = 0;
    longint m_icnt   = 0;
    longint m_scnt   = 0;
    logic   e_fetching, e_imem, e_dren, e_dwen, e_adv, e_wait;

    always_comb begin
        e_fetching = !m_halted && (m_op == 0);
        e_imem     = e_fetching && ifc.cu_iREN;
        e_dren     = (m_op == 1);
        e_dwen     = (m_op == 2);
        e_adv      = (e_fetching && ifc.ihit && !ifc.cu_halt && !ifc.cu_dREN && !ifc.cu_dWEN)
                     || ((m_op != 0) && ifc.dhit);
        e_wait     = (e_fetching && !ifc.ihit) || ((m_op != 0) && !ifc.dhit);
    end

    function automatic longint sat32(input longint v);
        return (v > MAX32) ? MAX32 : v;
    endfunction

    function automatic logic rnd(input int unsigned pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic set_in(input logic iren, input logic dren, input logic dwen,
                          input logic hlt, input logic ih, input logic dh);
        ifc.cu_iREN = iren;
        ifc.cu_dREN = dren;
        ifc.cu_dWEN = dwen;
        ifc.cu_halt = hlt;
        ifc.ihit    = ih;
        ifc.dhit    = dh;
        #1;
    endtask

    task automatic tick();
        bit rst, adv, wt, fet, ih, hl, dr, dw, dh;
        rst = nRST; adv = e_adv; wt = e_wait; fet = e_fetching;
        ih = ifc.ihit; hl = ifc.cu_halt; dr = ifc.cu_dREN; dw = ifc.cu_dWEN; dh = ifc.dhit;
        @(posedge CLK);
        #1;
        if (!rst) begin
            m_halted = 1'b0; m_op = 0; m_icnt = 0; m_scnt = 0;
        end else begin
            if (adv) m_icnt = sat32(m_icnt + 1);
            if (wt)  m_scnt = sat32(m_scnt + 1);
            if (fet && ih) begin
                if (hl)      m_halted = 1'b1;
                else if (dw) m_op = 2;
                else if (dr) m_op = 1;
            end else if ((m_op != 0) && dh) begin
                m_op = 0;
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'(i & 1), 1'b0, 1'b0, 1'b0, 1'((i >> 1) & 1), 1'b0);
            n_checks++;
            if ({ifc.imemREN, ifc.dmemREN, ifc.dmemWEN, ifc.pc_en, ifc.wb_en, ifc.halt}
                !== {1'(i & 1), 1'b0, 1'b0, 1'((i >> 1) & 1), 1'((i >> 1) & 1), 1'b0}) begin
                n_fail++;
                $display("FAIL reset_outputs combo %0d: got imem/dren/dwen/pc/wb/halt=%b%b%b%b%b%b", i,
                         ifc.imemREN, ifc.dmemREN, ifc.dmemWEN, ifc.pc_en, ifc.wb_en, ifc.halt);
            end
            n_checks++;
            if (ifc.instr_cnt !== 32'd0 || ifc.stall_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_counts: got %0d/%0d expected 0/0", ifc.instr_cnt, ifc.stall_cnt);
            end
            tick();
        end
    endtask

    task automatic test_straight();
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if ({ifc.imemREN, ifc.pc_en, ifc.wb_en} !== 3'b111) begin
                n_fail++;
                $display("FAIL straight_pc cycle %0d: got imem/pc/wb=%b%b%b expected 111", i,
                         ifc.imemREN, ifc.pc_en, ifc.wb_en);
            end
            tick();
        end
        n_checks++;
        if (ifc.instr_cnt !== 32'd5 || ifc.stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL straight_counts: got %0d/%0d expected 5/0", ifc.instr_cnt, ifc.stall_cnt);
        end
    endtask

    task automatic test_load();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({ifc.imemREN, ifc.pc_en, ifc.dmemREN} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_fetch: got imem/pc/dren=%b%b%b expected 100", ifc.imemREN, ifc.pc_en, ifc.dmemREN);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(rnd(50), rnd(50), rnd(50), rnd(50), 1'b1, 1'(k == 2));
            n_checks++;
            if ({ifc.dmemREN, ifc.dmemWEN, ifc.imemREN, ifc.pc_en} !== {3'b100, 1'(k == 2)}) begin
                n_fail++;
                $display("FAIL load_data cycle %0d: got dren/dwen/imem/pc=%b%b%b%b expected 100%b", k,
                         ifc.dmemREN, ifc.dmemWEN, ifc.imemREN, ifc.pc_en, 1'(k == 2));
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifc.stall_cnt !== 32'd2 || ifc.instr_cnt !== 32'd1 || ifc.dmemREN !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: got stall=%0d instr=%0d dren=%b expected 2/1/0",
                     ifc.stall_cnt, ifc.instr_cnt, ifc.dmemREN);
        end
    endtask

    task automatic test_both();
        int n;
        do_reset();
        n = int'($urandom_range(5, 1));
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < n; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'(k == n - 1));
            n_checks++;
            if ({ifc.dmemWEN, ifc.dmemREN} !== 2'b10) begin
                n_fail++;
                $display("FAIL both_write_wins cycle %0d: got dwen/dren=%b%b expected 10", k,
                         ifc.dmemWEN, ifc.dmemREN);
            end
            tick();
        end
        n_checks++;
        if (ifc.dmemWEN !== 1'b0 || ifc.instr_cnt !== 32'd1 || ifc.stall_cnt !== 32'(n - 1)) begin
            n_fail++;
            $display("FAIL both_done: got dwen=%b instr=%0d stall=%0d expected 0/1/%0d",
                     ifc.dmemWEN, ifc.instr_cnt, ifc.stall_cnt, n - 1);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (ifc.halt !== 1'b0 || ifc.pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_decode: got halt=%b pc=%b expected 0/0", ifc.halt, ifc.pc_en);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, rnd(50), rnd(50), rnd(50), 1'b1, rnd(50));
            n_checks++;
            if ({ifc.halt, ifc.imemREN, ifc.dmemREN, ifc.dmemWEN, ifc.pc_en, ifc.wb_en} !== 6'b100000
                || ifc.instr_cnt !== 32'd2 || ifc.stall_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL halted cycle %0d: got flags=%b%b%b%b%b%b cnt=%0d/%0d expected 100000 2/0", i,
                         ifc.halt, ifc.imemREN, ifc.dmemREN, ifc.dmemWEN, ifc.pc_en, ifc.wb_en,
                         ifc.instr_cnt, ifc.stall_cnt);
            end
            tick();
        end
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifc.halt !== 1'b0 || ifc.instr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got halt=%b instr=%0d expected 0/0", ifc.halt, ifc.instr_cnt);
        end
    endtask

    task automatic test_reset_mid_data();
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        nRST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifc.dmemREN !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_data_pending: got dren=%b expected 1", ifc.dmemREN);
        end
        tick();
        nRST = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({ifc.dmemREN, ifc.imemREN, ifc.pc_en} !== 3'b010 || ifc.instr_cnt !== 32'd0 || ifc.stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_data_reset: got dren/imem/pc=%b%b%b cnt=%0d/%0d expected 010 0/0",
                     ifc.dmemREN, ifc.imemREN, ifc.pc_en, ifc.instr_cnt, ifc.stall_cnt);
        end
        tick();
        n_checks++;
        if (ifc.instr_cnt !== 32'd0 || ifc.stall_cnt !== 32'd1 || ifc.dmemREN !== 1'b0) begin
            n_fail++;
            $display("FAIL dhit_in_fetch: got instr=%0d stall=%0d dren=%b expected 0/1/0",
                     ifc.instr_cnt, ifc.stall_cnt, ifc.dmemREN);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            nRST = !rnd(3);
            set_in(rnd(80), rnd(25), rnd(25), rnd(3), rnd(75), rnd(35));
            got = {ifc.imemREN, ifc.dmemREN, ifc.dmemWEN, ifc.pc_en, ifc.wb_en, ifc.halt};
            exp = {e_imem, e_dren, e_dwen, e_adv, e_adv, m_halted};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_outputs cycle %0d: got %b expected %b", c, got, exp);
            end
            n_checks++;
            if (ifc.instr_cnt !== m_icnt[31:0] || ifc.stall_cnt !== m_scnt[31:0]) begin
                n_fail++;
                $display("FAIL rand_counts cycle %0d: got %0d/%0d expected %0d/%0d", c,
                         ifc.instr_cnt, ifc.stall_cnt, m_icnt, m_scnt);
            end
            n_checks++;
            if (ifc.dmemREN && ifc.dmemWEN) begin
                n_fail++;
                $display("FAIL rand_exclusive cycle %0d: got dren=dwen=1 expected at most one", c);
            end
            tick();
        end
        nRST = 1'b1;
    endtask

    task automatic test_saturation();
        longint exp_cnt;
        ifc4.cu_iREN = 1'b1; ifc4.cu_dREN = 1'b0; ifc4.cu_dWEN = 1'b0;
        ifc4.cu_halt = 1'b0; ifc4.ihit = 1'b1; ifc4.dhit = 1'b0;
        nRST4 = 1'b0;
        @(posedge CLK);
        #1;
        nRST4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #1;
            exp_cnt = (k > 15) ? 15 : k;
            n_checks++;
            if (ifc4.instr_cnt !== 4'(exp_cnt) || ifc4.stall_cnt !== 4'd0 || ifc4.pc_en !== 1'b1) begin
                n_fail++;
                $display("FAIL sat4 retire %0d: got instr=%0d stall=%0d pc=%b expected %0d/0/1", k,
                         ifc4.instr_cnt, ifc4.stall_cnt, ifc4.pc_en, exp_cnt);
            end
        end
    endtask

    initial begin
        nRST  = 1'b0;
        nRST4 = 1'b0;
        ifc4.cu_iREN = 1'b0; ifc4.cu_dREN = 1'b0; ifc4.cu_dWEN = 1'b0;
        ifc4.cu_halt = 1'b0; ifc4.ihit = 1'b0; ifc4.dhit = 1'b0;
        test_reset();
        test_straight();
        test_load();
        test_both();
        test_halt();
        test_reset_mid_data();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
